dataflow_fork: RTL

//  Eager handshake fork: broadcasts one valid/ready input token to NUM_OUT consumers.

---
 rtl/dataflow_fork.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dataflow_fork.sv
// Eager 1-to-NUM_OUT valid/ready fork: every branch takes each token exactly once and the
// input retires once all branches have it. Define LOOM_FORK_SKID_EN for a 2-entry input skid FIFO.
module dataflow_fork #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data
);

    generate
        if (NUM_OUT < 2 || NUM_OUT > 8) begin : g_bad_num_out
            $fatal(1, "dataflow_fork: NUM_OUT=%0d outside legal range 2..8", NUM_OUT);
        end
    endgenerate

    logic [NUM_OUT-1:0] done_q;
    logic [NUM_OUT-1:0] done_d;
    logic [NUM_OUT-1:0] fire;
    logic               tok_valid;
    logic [WIDTH-1:0]   tok_data;
    logic               tok_done;
    logic               tok_retire;

    // A branch that already holds the token counts as finished even if it is not ready now.
    assign tok_done   = &(done_q | out_ready);
    assign tok_retire = tok_valid & tok_done;

`ifdef LOOM_FORK_SKID_EN
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             wr_ptr_q;
    logic             wr_ptr_d;
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    logic             not_full_q;
    logic             not_full_d;
    logic             push;
    logic             pop;

    // in_ready comes straight from a flop so out_ready never reaches the producer.
    assign in_ready  = not_full_q & ~rst;
    assign push      = in_valid & in_ready;
    assign tok_valid = (count_q != 2'd0) & ~rst;
    assign tok_data  = mem_q[rd_ptr_q];
    assign pop       = tok_retire;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        not_full_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            not_full_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            not_full_q <= not_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
`else
    assign tok_valid = in_valid & ~rst;
    assign tok_data  = in_data;
    assign in_ready  = tok_done & ~rst;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_branch
            assign out_valid[gi]                 = tok_valid & ~done_q[gi];
            assign fire[gi]                      = out_valid[gi] & out_ready[gi];
            assign out_data[gi*WIDTH +: WIDTH]   = tok_data;
        end
    endgenerate

    always_comb begin
        done_d = done_q | fire;
        if (tok_retire) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule
